// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code conversion helpers and end-of-range mode constants
package gray_pkg;
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int i = 31; i >= 0; i--) b[i] = ^(g >> i);
        return b;
    endfunction
endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational prefix-XOR Gray-to-binary converter
module gray2bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);
    genvar g;
    for (g = 0; g < WIDTH; g++) begin : g_bit
        assign bin[g] = ^gray[WIDTH-1:g];
    end
endmodule

// File: rtl/gray_updown_counter.sv
// gray_updown_counter: up/down Gray counter with load, wrap/saturate ends, wrap pulse and sticky overflow
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadGray,
    input  logic             OvfClr,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Binary,
    output logic             Wrap,
    output logic             Overflow
);
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] next_n;
    logic             end_ev;

    gray2bin #(.WIDTH(WIDTH)) u_load_conv (
        .gray (LoadGray),
        .bin  (load_bin)
    );

    // end event is a step that would leave the range; saturate mode turns it into a hold
    always_comb begin
        end_ev = En & ~Load & (Up ? &Binary : ~|Binary);
        next_n = Load ? load_bin
               : ~En ? Binary
               : (end_ev && SATURATE == MODE_SAT) ? Binary
               : Up ? Binary + WIDTH'(1) : Binary - WIDTH'(1);
    end

    // Output is derived from next_n so Binary and Output update on the same edge
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Binary   <= '0;
            Output   <= '0;
            Wrap     <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            Binary   <= next_n;
            Output   <= WIDTH'(bin2gray(32'(next_n)));
            Wrap     <= end_ev;
            Overflow <= (Overflow & ~OvfClr) | end_ev;
        end
    end
endmodule

// File: tb/tb_gray_updown_counter.sv
// tb_gray_updown_counter: directed scenarios plus random run against a behavioural model
module tb_gray_updown_counter;
    logic Clk = 0, Reset = 0, En = 0, Up = 0, Load = 0, OvfClr = 0;
    logic [4:0] lg = '0;
    logic [2:0] out_a, bin_a, out_s, bin_s;
    logic [4:0] out_w, bin_w;
    logic wrap_a, ovf_a, wrap_s, ovf_s, wrap_w, ovf_w;
    int n_chk = 0, n_pass = 0;
    int mn[3], mw[3], mo[3];
    localparam int MWID[3] = '{3, 3, 5};
    localparam int MSAT[3] = '{0, 1, 0};

    always #5 Clk = ~Clk;

    gray_updown_counter #(.WIDTH(3), .SATURATE(gray_pkg::MODE_WRAP)) u_a (
        .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .LoadGray(lg[2:0]), .OvfClr(OvfClr),
        .Output(out_a), .Binary(bin_a), .Wrap(wrap_a), .Overflow(ovf_a));
    gray_updown_counter #(.WIDTH(3), .SATURATE(gray_pkg::MODE_SAT)) u_s (
        .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .LoadGray(lg[2:0]), .OvfClr(OvfClr),
        .Output(out_s), .Binary(bin_s), .Wrap(wrap_s), .Overflow(ovf_s));
    gray_updown_counter #(.WIDTH(5), .SATURATE(gray_pkg::MODE_WRAP)) u_w (
        .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .LoadGray(lg), .OvfClr(OvfClr),
        .Output(out_w), .Binary(bin_w), .Wrap(wrap_w), .Overflow(ovf_w));

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int gray_decode(input int g);
        int b = 0;
        for (int s = 0; s < 32; s++) b ^= g >>> s;
        return b;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int top = (1 << MWID[k]) - 1;
            bit ev = 0;
            if (Reset) begin
                mn[k] = 0; mw[k] = 0; mo[k] = 0;
            end else begin
                if (Load) mn[k] = gray_decode(int'(lg) & top);
                else if (En) begin
                    ev = Up ? (mn[k] == top) : (mn[k] == 0);
                    if (!ev) mn[k] = Up ? mn[k] + 1 : mn[k] - 1;
                    else if (MSAT[k] == 0) mn[k] = Up ? 0 : top;
                end
                mw[k] = ev;
                mo[k] = (mo[k] != 0 && !OvfClr) || ev;
            end
        end
    endtask

    task automatic check_model();
        check("out_w3",  out_a,  mn[0] ^ (mn[0] >> 1));
        check("bin_w3",  bin_a,  mn[0]);
        check("wrap_w3", wrap_a, mw[0]);
        check("ovf_w3",  ovf_a,  mo[0]);
        check("out_s3",  out_s,  mn[1] ^ (mn[1] >> 1));
        check("bin_s3",  bin_s,  mn[1]);
        check("wrap_s3", wrap_s, mw[1]);
        check("ovf_s3",  ovf_s,  mo[1]);
        check("out_w5",  out_w,  mn[2] ^ (mn[2] >> 1));
        check("bin_w5",  bin_w,  mn[2]);
        check("wrap_w5", wrap_w, mw[2]);
        check("ovf_w5",  ovf_w,  mo[2]);
    endtask

    task automatic cycle(input logic rs, ld, e, u, c, input logic [4:0] g);
        Reset = rs; Load = ld; En = e; Up = u; OvfClr = c; lg = g;
        @(posedge Clk);
        model_step();
        #1;
        check_model();
    endtask

    initial begin
        int up_seq[8] = '{1, 3, 2, 6, 7, 5, 4, 0};
        int dn_out[3] = '{4, 5, 7};
        int dn_bin[3] = '{7, 6, 5};
        logic [2:0] p3;
        logic [4:0] p5;
        cycle(1, 0, 0, 0, 0, 0);
        check("rst_out", out_a, 0);
        check("rst_ovf", ovf_a, 0);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 1, 1, 0, 0);
            check("up_out", out_a, up_seq[i]);
            check("up_bin", bin_a, (i + 1) % 8);
            check("up_wrap", wrap_a, i == 7);
            check("up_ovf", ovf_a, i == 7);
        end
        cycle(0, 0, 0, 0, 1, 0);
        check("ovfclr_alone", ovf_a, 0);
        cycle(0, 0, 1, 0, 1, 0);
        check("ovfclr_vs_set", ovf_a, 1);
        check("ovfclr_wrap", wrap_a, 1);
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 0, 0, 0);
            check("dn_out", out_a, dn_out[i]);
            check("dn_bin", bin_a, dn_bin[i]);
            check("dn_wrap", wrap_a, i == 0);
        end
        cycle(0, 1, 1, 1, 0, 5'b00110);
        check("load_bin", bin_a, 4);
        check("load_out", out_a, 6);
        check("load_wrap", wrap_a, 0);
        cycle(0, 0, 1, 1, 0, 0);
        check("after_load", out_a, 7);
        cycle(0, 1, 0, 0, 0, 5'b00100);
        check("sat_load_bin", bin_s, 7);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 1, 0, 0);
            check("sat_hold_out", out_s, 4);
            check("sat_hold_wrap", wrap_s, 1);
            check("sat_hold_ovf", ovf_s, 1);
        end
        cycle(0, 0, 1, 0, 0, 0);
        check("sat_down_out", out_s, 5);
        cycle(0, 0, 1, 1, 0, 0);
        cycle(0, 1, 1, 1, 0, 5'b10110);
        cycle(1, 0, 1, 1, 0, 0);
        check("rst_mid_load", out_w, 0);
        for (int i = 0; i < 10000; i++) begin
            logic rs, ld, e;
            rs = (i == 5000) || ($urandom_range(0, 499) == 0);
            ld = $urandom_range(0, 15) == 0;
            e = $urandom_range(0, 3) != 0;
            p3 = out_a;
            p5 = out_w;
            cycle(rs, ld, e, 1'($urandom), $urandom_range(0, 15) == 0, 5'($urandom));
            if (rs) begin
                check("rnd_rst_out", out_w, 0);
                check("rnd_rst_bin", bin_w, 0);
            end else if (!ld && e) begin
                check("onebit_w5", $countones(out_w ^ p5), 1);
                check("onebit_w3", $countones(out_a ^ p3), 1);
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
